park_occupancy_counter: RTL

- Parametrised car-park occupancy tracker. Successor to the fixed 4-bit, up-only, enable-driven counter.
- Takes raw level signals from the entry and exit gate sensors and edge-detects them internally.
- Keeps a saturating up/down count of parked cars, bounded by CAPACITY, and supports preload.
- Drives full/empty/almost-full status, free-slot count and sticky error flags to the gate controller and display logic.

---
 rtl/park_occupancy_counter.sv | 91 +++++++++
 1 files changed

// File: rtl/park_occupancy_counter.sv
// Car-park occupancy tracker: edge-detected entry/exit sensors, saturating count and sticky errors.
// Optional peak-occupancy register enabled by defining PARK_PEAK_TRACK_EN.
module park_occupancy_counter #(
  parameter int WIDTH         = 8,
  parameter int CAPACITY      = 200,
  parameter int ALMOST_MARGIN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             entry_sense,
  input  logic             exit_sense,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] free_slots,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             overflow_err,
  output logic             underflow_err,
  output logic [WIDTH-1:0] peak_count
);

  localparam logic [WIDTH-1:0] CAP    = WIDTH'(CAPACITY);
  localparam logic [WIDTH-1:0] MARGIN = WIDTH'(ALMOST_MARGIN);

  logic             entry_q, exit_q;
  logic             ent_ev, ext_ev;
  logic [WIDTH-1:0] count_next;
  logic             ovf_set, unf_set;

  assign ent_ev = entry_sense & ~entry_q;
  assign ext_ev = exit_sense & ~exit_q;

  // Load beats events; simultaneous entry and exit is a car passing through.
  always_comb begin
    count_next = count;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    if (load) begin
      if (load_val > CAP) begin
        count_next = CAP;
        ovf_set    = 1'b1;
      end else begin
        count_next = load_val;
      end
    end else if (ent_ev && !ext_ev) begin
      if (count < CAP) count_next = count + 1'b1;
      else             ovf_set    = 1'b1;
    end else if (ext_ev && !ent_ev) begin
      if (count != '0) count_next = count - 1'b1;
      else             unf_set    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q       <= 1'b0;
      exit_q        <= 1'b0;
      count         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      entry_q       <= entry_sense;
      exit_q        <= exit_sense;
      count         <= count_next;
      overflow_err  <= ovf_set | (overflow_err & ~clr_err);
      underflow_err <= unf_set | (underflow_err & ~clr_err);
    end
  end

  assign free_slots  = CAP - count;
  assign full        = (count == CAP);
  assign empty       = (count == '0);
  assign almost_full = (free_slots <= MARGIN);

`ifdef PARK_PEAK_TRACK_EN
  logic [WIDTH-1:0] peak_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  peak_q <= '0;
    else if (count_next > peak_q) peak_q <= count_next;
  end

  assign peak_count = peak_q;
`else
  assign peak_count = '0;
`endif

endmodule
